// File: rtl/mips_io_port_pkg.sv
// rtl/mips_io_port_pkg.sv - shared I/O map constants for the mini MIPS I/O port
//
// Purpose: address map and default sizing shared by the I/O port RTL and the
//          CPU test programs (switches at IO_BASE+0, status +1, LEDs +2).
// Contents: default WIDTH/DB_CYCLES/IO_BASE, register offset enum, decode helper.
package mips_io_port_pkg;

  localparam int         WIDTH_DEF     = 8;
  localparam int         DB_CYCLES_DEF = 4;
  localparam logic [7:0] IO_BASE_DEF   = 8'hFC;

  // Register offsets from IO_BASE.
  typedef enum logic [1:0] {
    OFF_SW   = 2'd0,
    OFF_STAT = 2'd1,
    OFF_LED  = 2'd2,
    OFF_RSVD = 2'd3
  } io_off_e;

  // Everything at or above the base belongs to this block; exmem lives below it.
  function automatic logic is_io(input logic [7:0] a, input logic [7:0] base);
    return a >= base;
  endfunction

endpackage

// File: rtl/mips_io_port_switch_debounce.sv
// rtl/mips_io_port_switch_debounce.sv - switch synchroniser and whole-vector debouncer
//
// Purpose: brings the asynchronous switch pins into the clk domain through a
//          2-FF chain, then accepts a new value only after DB_CYCLES consecutive
//          identical samples that differ from the current stable value.
// Ports:
//   clk        in   1      system clock
//   rst        in   1      synchronous active-low reset
//   switches   in   WIDTH  raw board switches
//   stable     out  WIDTH  debounced switch value
//   chg_pulse  out  1      high for the single cycle whose edge loads a new stable value
module mips_io_port_switch_debounce #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] stable,
  output logic             chg_pulse
);

  localparam int             CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync_q;
  // Previous synchronised sample: lets us spot a switch to a different
  // candidate value while a count is already running.
  logic [WIDTH-1:0] sync_d;
  logic [CW-1:0]    cnt;

  logic differs;
  logic restart;
  logic accept;

  assign differs   = (sync_q != stable);
  assign restart   = (cnt != '0) && (sync_q != sync_d);
  assign accept    = differs && !restart && (cnt == CNT_LAST);
  // Combinational so the top can set its change flag on the same edge that
  // loads the new stable value.
  assign chg_pulse = accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a <= '0;
      sync_q <= '0;
      sync_d <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync_a <= switches;
      sync_q <= sync_a;
      sync_d <= sync_q;
      if (!differs) begin
        cnt <= '0;
      end else if (restart) begin
        cnt <= CW'(1);
      end else if (accept) begin
        stable <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mips_io_port.sv
// rtl/mips_io_port.sv - memory-mapped switch/LED responder for the mini MIPS data bus
//
// Purpose: decodes IO_BASE..IO_BASE+3, returns registered read data one cycle
//          after the address (like exmem), keeps a sticky switch-change flag
//          and the LED register.
// Ports:
//   clk        in   1      system clock
//   rst        in   1      synchronous active-low reset
//   adr        in   8      CPU byte address
//   memwrite   in   1      CPU write strobe
//   writedata  in   WIDTH  CPU write data
//   io_sel     out  1      combinational: adr is in the I/O window
//   iodata     out  WIDTH  registered read data
//   switches   in   WIDTH  raw board switches
//   LEDS       out  WIDTH  LED register
module mips_io_port
  import mips_io_port_pkg::*;
#(
  parameter int         WIDTH     = WIDTH_DEF,
  parameter logic [7:0] IO_BASE   = IO_BASE_DEF,
  parameter int         DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       adr,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] writedata,
  output logic             io_sel,
  output logic [WIDTH-1:0] iodata,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] LEDS
);

  logic [WIDTH-1:0] sw_stable;
  logic             chg_pulse;
  logic             chg;
  io_off_e          off;
  logic             rd_en;
  logic             rd_sw;
  logic             wr_led;
  logic [WIDTH-1:0] rd_mux;

  mips_io_port_switch_debounce #(
    .WIDTH     (WIDTH),
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .switches  (switches),
    .stable    (sw_stable),
    .chg_pulse (chg_pulse)
  );

  assign io_sel = is_io(adr, IO_BASE);
  assign off    = io_off_e'(2'(adr - IO_BASE));
  assign rd_en  = io_sel && !memwrite;
  assign rd_sw  = rd_en && (off == OFF_SW);
  assign wr_led = io_sel && memwrite && (off == OFF_LED);

  always_comb begin
    rd_mux = '0;
    unique case (off)
      OFF_SW:   rd_mux = sw_stable;
      OFF_STAT: rd_mux = {{(WIDTH-1){1'b0}}, chg};
      OFF_LED:  rd_mux = LEDS;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      iodata <= '0;
      LEDS   <= '0;
      chg    <= 1'b0;
    end else begin
      if (rd_en) begin
        iodata <= rd_mux;
      end
      if (wr_led) begin
        LEDS <= writedata;
      end
      // A new value arriving on the same edge as a SW read must not be lost.
      if (chg_pulse) begin
        chg <= 1'b1;
      end else if (rd_sw) begin
        chg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_io_port.sv
// tb/tb_mips_io_port.sv - self-checking bench for mips_io_port
module tb_mips_io_port;

  localparam int         DB      = 4;
  localparam logic [7:0] BASE    = 8'hFC;
  localparam logic [7:0] A_SW    = 8'hFC;
  localparam logic [7:0] A_STAT  = 8'hFD;
  localparam logic [7:0] A_LED   = 8'hFE;
  localparam logic [7:0] A_R3    = 8'hFF;
  localparam logic [7:0] A_LOW   = 8'h10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] adr;
  logic       memwrite;
  logic [7:0] writedata;
  logic       io_sel;
  logic [7:0] iodata;
  logic [7:0] switches;
  logic [7:0] LEDS;

  mips_io_port #(.WIDTH(8), .IO_BASE(BASE), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .adr       (adr),
    .memwrite  (memwrite),
    .writedata (writedata),
    .io_sel    (io_sel),
    .iodata    (iodata),
    .switches  (switches),
    .LEDS      (LEDS)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pins reach the debouncer two edges late; a value is
  // accepted when the last DB samples are all equal to it and it is new.
  logic [7:0] pin_q[$];
  logic [7:0] samp_q[$];
  logic [7:0] m_stable, m_io, m_leds;
  logic       m_chg;

  function automatic void model_reset();
    pin_q = {8'h00, 8'h00};
    samp_q.delete();
    for (int i = 0; i < DB; i++) samp_q.push_back(8'h00);
    m_stable = 8'h00;
    m_io     = 8'h00;
    m_leds   = 8'h00;
    m_chg    = 1'b0;
  endfunction

  function automatic void model_edge(input logic r, input logic [7:0] a, input logic w,
                                     input logic [7:0] d, input logic [7:0] s);
    logic [7:0] sample;
    logic       accept;
    logic       rd;
    if (!r) begin
      model_reset();
      return;
    end
    sample = pin_q.pop_front();
    pin_q.push_back(s);
    void'(samp_q.pop_front());
    samp_q.push_back(sample);
    accept = (sample != m_stable);
    foreach (samp_q[i]) if (samp_q[i] != sample) accept = 1'b0;
    rd = (a >= BASE) && !w;
    if (rd) begin
      if (a == A_SW)        m_io = m_stable;
      else if (a == A_STAT) m_io = {7'b0, m_chg};
      else if (a == A_LED)  m_io = m_leds;
      else                  m_io = 8'h00;
    end
    if (accept)               m_chg = 1'b1;
    else if (rd && a == A_SW) m_chg = 1'b0;
    if (w && a == A_LED) m_leds = d;
    if (accept) m_stable = sample;
  endfunction

  // Called just after a negedge; returns just after the following negedge.
  task automatic apply(input logic r, input logic [7:0] a, input logic w,
                       input logic [7:0] d, input logic [7:0] s);
    rst = r; adr = a; memwrite = w; writedata = d; switches = s;
    #1 check("io_sel", {7'b0, io_sel}, {7'b0, (a >= BASE)});
    @(posedge clk);
    model_edge(r, a, w, d, s);
    #1;
    check("model_iodata", iodata, m_io);
    check("model_leds", LEDS, m_leds);
    @(negedge clk);
  endtask

  typedef struct {
    logic       r;
    logic [7:0] a;
    logic       w;
    logic [7:0] d;
    logic [7:0] s;
    logic       ck;
    logic [7:0] eio;
    logic [7:0] eled;
  } vec_t;

  vec_t tbl[$];

  function automatic void tv(input logic r, input logic [7:0] a, input logic w,
                             input logic [7:0] d, input logic [7:0] s,
                             input logic ck, input logic [7:0] eio, input logic [7:0] eled);
    vec_t v;
    v = '{r, a, w, d, s, ck, eio, eled};
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] cur_sw;
    // Reset with switches already set
    for (int k = 0; k < 4; k++) tv(0, A_SW, 0, 8'h00, 8'hA5, 1, 8'h00, 8'h00);
    // SW shows A5 only on the read after the 2+DB edge latency
    for (int k = 1; k <= 8; k++) tv(1, A_SW, 0, 8'h00, 8'hA5, 1, (k >= 7) ? 8'hA5 : 8'h00, 8'h00);
    tv(1, A_STAT, 0, 8'h00, 8'hA5, 1, 8'h00, 8'h00);
    // Return to 0 and clear the flag
    for (int k = 1; k <= 8; k++) tv(1, A_STAT, 0, 8'h00, 8'h00, (k >= 7), 8'h01, 8'h00);
    tv(1, A_SW, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    // Bounce 07<->00 every 2 cycles: never accepted
    for (int k = 0; k < 12; k++) tv(1, A_SW, 0, 8'h00, ((k % 4) < 2) ? 8'h07 : 8'h00, 1, 8'h00, 8'h00);
    // Settle at 07
    for (int k = 1; k <= 8; k++) tv(1, A_SW, 0, 8'h00, 8'h07, 1, (k >= 7) ? 8'h07 : 8'h00, 8'h00);
    // Change flag on 08
    for (int k = 1; k <= 8; k++) tv(1, A_STAT, 0, 8'h00, 8'h08, 1, (k >= 7) ? 8'h01 : 8'h00, 8'h00);
    tv(1, A_SW,   0, 8'h00, 8'h08, 1, 8'h08, 8'h00);
    tv(1, A_STAT, 0, 8'h00, 8'h08, 1, 8'h00, 8'h00);
    // SW read on the same edge that accepts 02: old value, flag set
    for (int k = 1; k <= 5; k++) tv(1, A_STAT, 0, 8'h00, 8'h02, 1, 8'h00, 8'h00);
    tv(1, A_SW,   0, 8'h00, 8'h02, 1, 8'h08, 8'h00);
    tv(1, A_STAT, 0, 8'h00, 8'h02, 1, 8'h01, 8'h00);
    // Write to SW address is ignored
    tv(1, A_SW,   1, 8'hFF, 8'h02, 1, 8'h01, 8'h00);
    tv(1, A_STAT, 0, 8'h00, 8'h02, 1, 8'h01, 8'h00);
    tv(1, A_SW,   0, 8'h00, 8'h02, 1, 8'h02, 8'h00);
    // LED write and readback; writes elsewhere ignored
    tv(1, A_LED,  1, 8'h59, 8'h02, 1, 8'h02, 8'h59);
    tv(1, A_LED,  0, 8'h00, 8'h02, 1, 8'h59, 8'h59);
    tv(1, A_R3,   1, 8'h3C, 8'h02, 1, 8'h59, 8'h59);
    tv(1, A_STAT, 1, 8'hAA, 8'h02, 1, 8'h59, 8'h59);
    // Decode boundary
    tv(1, 8'hFB,  0, 8'h00, 8'h02, 1, 8'h59, 8'h59);
    tv(1, 8'hFB,  1, 8'h77, 8'h02, 1, 8'h59, 8'h59);
    tv(1, A_R3,   0, 8'h00, 8'h02, 1, 8'h00, 8'h59);
    tv(1, A_LOW,  0, 8'h00, 8'h02, 1, 8'h00, 8'h59);
    // Mid-operation reset during a count, after LED=33
    tv(1, A_LED,  1, 8'h33, 8'h02, 1, 8'h00, 8'h33);
    for (int k = 0; k < 4; k++) tv(1, A_LOW, 0, 8'h00, 8'h11, 1, 8'h00, 8'h33);
    tv(0, A_LED,  1, 8'h99, 8'h11, 1, 8'h00, 8'h00);
    for (int k = 1; k <= 8; k++) tv(1, A_SW, 0, 8'h00, 8'h11, 1, (k >= 7) ? 8'h11 : 8'h00, 8'h00);
    tv(1, A_STAT, 0, 8'h00, 8'h11, 1, 8'h00, 8'h00);

    rst = 1'b0; adr = 8'h00; memwrite = 1'b0; writedata = 8'h00; switches = 8'h00;
    model_reset();
    @(negedge clk);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s);
      if (tbl[i].ck) begin
        check($sformatf("tbl_iodata[%0d]", i), iodata, tbl[i].eio);
        check($sformatf("tbl_leds[%0d]", i), LEDS, tbl[i].eled);
      end
    end

    // Randomised traffic against the model
    cur_sw = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] a;
      if ($urandom_range(0, 5) == 0) cur_sw = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) a = 8'($urandom_range(0, 255));
      else                           a = BASE + 8'($urandom_range(0, 3));
      apply(($urandom_range(0, 79) != 0), a, ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 255)), cur_sw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
